vga_frame_reader: RTL and testbench



---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_timing.sv | 79 +++++++
 rtl/vga_frame_reader.sv | 120 ++++++++++++
 tb/tb_vga_frame_reader.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, frame-buffer size and colour-bar palette.
// Also used by the upstream UART write path for its address wrap.
package vga_pkg;
  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int FB_PIXELS = H_VISIBLE * V_VISIBLE;
  localparam int ADDR_W    = 19;
  localparam int BAR_COUNT = 8;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction
endpackage

// File: rtl/vga_timing.sv
// Pixel-enable divider, h/v raster counters and registered region/sync flags
// that always describe the pixel the counters currently point at.
module vga_timing #(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FP      = vga_pkg::H_FP,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BP      = vga_pkg::H_BP,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FP      = vga_pkg::V_FP,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BP      = vga_pkg::V_BP
) (
  input  logic       clk,
  input  logic       rst,
  output logic       o_pix_en,
  output logic [9:0] o_h,
  output logic       o_visible,
  output logic       o_hs_act,
  output logic       o_vs_act,
  output logic       o_frame_wrap
);
  localparam logic [9:0] H_LAST    = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST    = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_END = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START  = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic       r_pix_en;
  logic [9:0] r_h;
  logic [9:0] r_v;
  logic       r_visible;
  logic       r_hs_act;
  logic       r_vs_act;
  logic       w_h_last;
  logic       w_v_last;
  logic [9:0] w_h_next;
  logic [9:0] w_v_next;

  always_comb begin
    w_h_last = (r_h == H_LAST);
    w_v_last = (r_v == V_LAST);
    w_h_next = w_h_last ? 10'd0 : r_h + 10'd1;
    w_v_next = r_v;
    if (w_h_last) begin
      w_v_next = w_v_last ? 10'd0 : r_v + 10'd1;
    end
  end

  // Flags are computed from the next position so they stay aligned with r_h/r_v.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix_en  <= 1'b0;
      r_h       <= 10'd0;
      r_v       <= 10'd0;
      r_visible <= 1'b1;
      r_hs_act  <= 1'b0;
      r_vs_act  <= 1'b0;
    end else begin
      r_pix_en <= ~r_pix_en;
      if (r_pix_en) begin
        r_h       <= w_h_next;
        r_v       <= w_v_next;
        r_visible <= (w_h_next < H_VIS_END) && (w_v_next < V_VIS_END);
        r_hs_act  <= (w_h_next >= HS_START) && (w_h_next < HS_END);
        r_vs_act  <= (w_v_next >= VS_START) && (w_v_next < VS_END);
      end
    end
  end

  assign o_pix_en     = r_pix_en;
  assign o_h          = r_h;
  assign o_visible    = r_visible;
  assign o_hs_act     = r_hs_act;
  assign o_vs_act     = r_vs_act;
  assign o_frame_wrap = r_pix_en & w_h_last & w_v_last;
endmodule

// File: rtl/vga_frame_reader.sv
// Raster read-address generator for the frame buffer plus the one-stage VGA
// output pipeline (source mux, syncs, blanking) feeding the ADV7123 DAC.
module vga_frame_reader #(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FP      = vga_pkg::H_FP,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BP      = vga_pkg::H_BP,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FP      = vga_pkg::V_FP,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BP      = vga_pkg::V_BP,
  parameter int ADDR_W    = vga_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              display_en,
  input  logic              test_pattern,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        pixel_data,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_N,
  output logic              VGA_SYNC_N,
  output logic              VGA_CLK,
  output logic              frame_start
);
  import vga_pkg::*;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_VISIBLE * V_VISIBLE - 1);
  localparam int                BAR_W     = H_VISIBLE / BAR_COUNT;

  logic              w_pix_en;
  logic [9:0]        w_h;
  logic              w_visible;
  logic              w_hs_act;
  logic              w_vs_act;
  logic              w_frame_wrap;
  logic [2:0]        w_bar;
  logic [23:0]       w_rgb;
  logic [ADDR_W-1:0] r_addr;
  logic [23:0]       r_rgb;
  logic              r_hs_n;
  logic              r_vs_n;
  logic              r_blank_n;
  logic              r_frame_start;

  vga_timing #(
    .H_VISIBLE(H_VISIBLE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VISIBLE(V_VISIBLE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk          (clk),
    .rst          (rst),
    .o_pix_en     (w_pix_en),
    .o_h          (w_h),
    .o_visible    (w_visible),
    .o_hs_act     (w_hs_act),
    .o_vs_act     (w_vs_act),
    .o_frame_wrap (w_frame_wrap)
  );

  // Saturating at the last pixel keeps the address inside the buffer through
  // the vertical blanking interval until the frame wrap clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
    end else if (w_pix_en) begin
      if (w_frame_wrap) begin
        r_addr <= '0;
      end else if (w_visible && (r_addr != ADDR_LAST)) begin
        r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    w_bar = 3'd0;
    for (int i = 1; i < BAR_COUNT; i++) begin
      if (int'(w_h) >= i * BAR_W) begin
        w_bar = 3'(i);
      end
    end
  end

  always_comb begin
    w_rgb = 24'd0;
    if (w_visible && display_en) begin
      w_rgb = test_pattern ? bar_colour(w_bar) : {3{pixel_data}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rgb         <= 24'd0;
      r_hs_n        <= 1'b1;
      r_vs_n        <= 1'b1;
      r_blank_n     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame_wrap;
      if (w_pix_en) begin
        r_rgb     <= w_rgb;
        r_hs_n    <= ~w_hs_act;
        r_vs_n    <= ~w_vs_act;
        r_blank_n <= w_visible;
      end
    end
  end

  assign rd_addr               = r_addr;
  assign {VGA_R, VGA_G, VGA_B} = r_rgb;
  assign VGA_HS                = r_hs_n;
  assign VGA_VS                = r_vs_n;
  assign VGA_BLANK_N           = r_blank_n;
  assign VGA_SYNC_N            = 1'b0;
  assign VGA_CLK               = w_pix_en;
  assign frame_start           = r_frame_start;
endmodule

// File: tb/tb_vga_frame_reader.sv
// Randomised bench for vga_frame_reader: full horizontal geometry, shortened
// vertical geometry so several frames fit; raster-position model predicts every clk.
module tb_vga_frame_reader;
  localparam int HV = 640, HFP = 16, HSY = 96, HBP = 48;
  localparam int HT = HV + HFP + HSY + HBP;
  localparam int VV = 6, VFP = 1, VSY = 2, VBP = 2;
  localparam int VT = VV + VFP + VSY + VBP;
  localparam int FRAME_PIX  = HT * VT;
  localparam int FRAME_CLKS = 2 * FRAME_PIX;
  localparam int ADDR_LAST  = HV * VV - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        display_en = 1'b1;
  logic        test_pattern = 1'b0;
  logic [18:0] rd_addr;
  logic [7:0]  pixel_data;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, frame_start;

  int          n_checks = 0;
  int          n_errors = 0;
  int          c = 0;
  bit          m_den = 1'b1;
  bit          m_tp = 1'b0;
  logic [23:0] bars [8];

  vga_frame_reader #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .ADDR_W(19)
  ) dut (
    .clk(clk), .rst(rst), .display_en(display_en), .test_pattern(test_pattern),
    .rd_addr(rd_addr), .pixel_data(pixel_data),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_SYNC_N(VGA_SYNC_N), .VGA_CLK(VGA_CLK), .frame_start(frame_start)
  );

  always #10 clk = ~clk;

  // Frame buffer model: mem[a] = a[7:0], one clk read latency.
  always @(posedge clk) pixel_data <= rd_addr[7:0];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int exp_addr(input int p);
    int h, v;
    h = p % HT;
    v = p / HT;
    if (v >= VV) return ADDR_LAST;
    if (h < HV) return v * HV + h;
    return ((v + 1) * HV > ADDR_LAST) ? ADDR_LAST : (v + 1) * HV;
  endfunction

  function automatic logic [23:0] exp_rgb(input int p, input bit den, input bit tp);
    int h, v;
    logic [7:0] b;
    h = p % HT;
    v = p / HT;
    if (h >= HV || v >= VV || !den) return 24'd0;
    if (tp) return bars[h / (HV / 8)];
    b = 8'((v * HV + h) % 256);
    return {b, b, b};
  endfunction

  // c = rising edges since reset release; every 2nd edge is a pixel edge.
  task automatic check_outputs();
    int k, p, q, hq, vq;
    logic [23:0] e_rgb;
    logic [5:0] e_sync;
    bit e_clk, e_hs, e_vs, e_bl, e_fs;
    k = c / 2;
    p = k % FRAME_PIX;
    q = (k + FRAME_PIX - 1) % FRAME_PIX;
    hq = q % HT;
    vq = q / HT;
    e_clk = (c % 2) == 1;
    if (k == 0) begin
      e_rgb = 24'd0;
      e_sync = {1'b1, 1'b1, 1'b0, 1'b0, e_clk, 1'b0};
    end else begin
      e_rgb = exp_rgb(q, m_den, m_tp);
      e_hs = !(hq >= HV + HFP && hq < HV + HFP + HSY);
      e_vs = !(vq >= VV + VFP && vq < VV + VFP + VSY);
      e_bl = (hq < HV) && (vq < VV);
      e_fs = ((c % 2) == 0) && (p == 0);
      e_sync = {e_hs, e_vs, e_bl, 1'b0, e_clk, e_fs};
    end
    check_eq("rgb", {VGA_R, VGA_G, VGA_B}, e_rgb);
    check_eq("sync", {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, frame_start}, e_sync);
    check_eq("addr", rd_addr, exp_addr(p));
    if (k > 0 && (c % 2) == 0) begin
      if (p == HT + 5) check_eq("addr_h5v1", rd_addr, 645);
      if (q == HT + 5 && m_den && !m_tp) check_eq("rgb_h5v1", {VGA_R, VGA_G, VGA_B}, 24'h858585);
      if (m_den && m_tp && vq < VV && hq == 85) check_eq("bar_x85", {VGA_R, VGA_G, VGA_B}, 24'hFFFF00);
      if (m_den && m_tp && vq < VV && hq == 600) check_eq("bar_x600", {VGA_R, VGA_G, VGA_B}, 24'h000000);
      if (p == VV * HT) check_eq("addr_hold", rd_addr, ADDR_LAST);
      if (p == 0) begin
        check_eq("addr_wrap", rd_addr, 0);
        check_eq("frame_start", frame_start, 1);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      c = 0;
    end else begin
      c++;
      if ((c % 2) == 0) begin
        m_den = display_en;
        m_tp = test_pattern;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic maybe_randomize();
    if ($urandom_range(0, 199) == 0) begin
      display_en = 1'($urandom_range(0, 1));
      test_pattern = 1'($urandom_range(0, 1));
      $display("t=%0t pos=(%0d,%0d) display_en=%0b test_pattern=%0b", $time,
               ((c / 2) % FRAME_PIX) % HT, ((c / 2) % FRAME_PIX) / HT, display_en, test_pattern);
    end
  endtask

  initial begin
    int v;
    bit found;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    repeat (5) tick();
    rst = 1'b0;
    $display("t=%0t reset released", $time);

    // Frame 0: scripted modes per line; frame 1: random mode changes.
    for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
      v = ((c / 2) % FRAME_PIX) / HT;
      if (i < FRAME_CLKS && v < 3) begin
        display_en = 1'b1;
        test_pattern = 1'b0;
      end else if (i < FRAME_CLKS && v == 3) begin
        display_en = 1'b1;
        test_pattern = 1'b1;
      end else if (i < FRAME_CLKS && v == 4) begin
        display_en = 1'b0;
        test_pattern = 1'($urandom_range(0, 1));
      end else begin
        maybe_randomize();
      end
      tick();
    end

    found = 1'b0;
    for (int i = 0; i < FRAME_CLKS && !found; i++) begin
      if ((c % 2) == 0 && ((c / 2) % FRAME_PIX) == 2 * HT + 300) found = 1'b1;
      else tick();
    end
    check_eq("reach_h300v2", found, 1);

    #3 rst = 1'b1;
    #1 c = 0;
    $display("t=%0t mid-line reset asserted", $time);
    check_outputs();
    repeat (3) tick();
    rst = 1'b0;
    $display("t=%0t reset released", $time);
    for (int i = 0; i < FRAME_CLKS + 4000; i++) begin
      maybe_randomize();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
